// File: rtl/uart_rx_sampler.sv
`default_nettype none
// =============================================================================
// Module   : uart_rx_sampler
// Brief    : 16x-oversampled 8-bit UART receiver with 3-sample majority vote,
//            valid/ack byte register and sticky framing/overrun flags.
//            Optional even-parity check is enabled with macro UART_RX_PARITY_EN.
// Revision : 1.0
// =============================================================================
module uart_rx_sampler #(
  parameter int OVS    = 16,
  parameter int VOTE_T = 7
) (
  input  logic       sam_clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  localparam logic [3:0] c_TICK_LAST = 4'(OVS - 1);
  localparam logic [3:0] c_TICK_V0   = 4'(VOTE_T);
  localparam logic [3:0] c_TICK_V1   = 4'(VOTE_T + 1);
  localparam logic [3:0] c_TICK_V2   = 4'(VOTE_T + 2);

  logic       r_sync1, r_sync2;
  logic [2:0] r_state;
  logic [3:0] r_tick;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shreg;
  logic       r_v0, r_v1;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ferr;
  logic       r_ovr;

  logic w_rx_s;
  logic w_vote;
  logic w_vote_tick;
  logic w_last_tick;
  logic w_done;

  assign w_rx_s      = r_sync2;
  assign w_vote      = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);
  assign w_vote_tick = (r_tick == c_TICK_V2);
  assign w_last_tick = (r_tick == c_TICK_LAST);
  // Byte completes on the stop-bit vote; the rest of the stop bit is not waited for.
  assign w_done      = (r_state == c_ST_STOP) && w_vote_tick;

  always_ff @(posedge sam_clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= c_ST_IDLE;
      r_tick    <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'h00;
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      if (r_tick == c_TICK_V0) r_v0 <= w_rx_s;
      if (r_tick == c_TICK_V1) r_v1 <= w_rx_s;
      case (r_state)
        c_ST_IDLE: begin
          r_tick <= 4'd0;
          if (!w_rx_s) r_state <= c_ST_START;
        end
        c_ST_START: begin
          r_tick <= r_tick + 4'd1;
          if (w_vote_tick && w_vote) begin
            r_state <= c_ST_IDLE;
            r_tick  <= 4'd0;
          end else if (w_last_tick) begin
            r_state   <= c_ST_DATA;
            r_bit_idx <= 3'd0;
          end
        end
        c_ST_DATA: begin
          r_tick <= r_tick + 4'd1;
          if (w_vote_tick) r_shreg <= {w_vote, r_shreg[7:1]};
          if (w_last_tick) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= c_ST_PARITY;
`else
              r_state <= c_ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        c_ST_PARITY: begin
          r_tick <= r_tick + 4'd1;
          if (w_last_tick) r_state <= c_ST_STOP;
        end
`endif
        c_ST_STOP: begin
          r_tick <= r_tick + 4'd1;
          if (w_vote_tick) begin
            r_state <= c_ST_IDLE;
            r_tick  <= 4'd0;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_tick  <= 4'd0;
        end
      endcase
    end
  end

  // A completing byte takes priority over an ack on the same edge, keeping rx_valid set.
  always_ff @(posedge sam_clk or negedge reset) begin
    if (!reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_done) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (rx_ack) begin
        r_valid <= 1'b0;
      end
      r_ferr <= (r_ferr & ~err_clr) | (w_done & ~w_vote);
      r_ovr  <= (r_ovr & ~err_clr) | (w_done & r_valid & ~rx_ack);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_perr;
  logic w_par_evt;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_evt = (r_state == c_ST_PARITY) && w_vote_tick && ((^r_shreg) ^ w_vote);

  always_ff @(posedge sam_clk or negedge reset) begin
    if (!reset) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= (r_perr & ~err_clr) | w_par_evt;
    end
  end

  assign parity_err = r_perr;
`endif

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign busy      = (r_state != c_ST_IDLE);
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// Testbench for uart_rx_sampler: directed and random frames checked against a
// frame-level reference model of the receive register and sticky flags.
module tb_uart_rx_sampler;

  localparam int c_BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int c_NBITS = 11;
`else
  localparam int c_NBITS = 10;
`endif
  localparam int c_LAT = 2 + (c_NBITS - 1) * c_BIT + 10;

  logic       sam_clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_sampler #(.OVS(16), .VOTE_T(7)) u_dut (
    .sam_clk   (sam_clk),
    .reset     (reset),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 sam_clk = ~sam_clk;

  int cyc = 0;
  always @(posedge sam_clk) cyc <= cyc + 1;

  // Edge monitor: cycle stamps of rx_valid and busy rising edges
  int valid_rise_cyc = -1;
  int busy_rise_cyc  = -1;
  int valid_rises    = 0;
  logic prev_valid = 1'b0;
  logic prev_busy  = 1'b0;
  always @(negedge sam_clk) begin
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      valid_rise_cyc = cyc;
      valid_rises++;
    end
    if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise_cyc = cyc;
    prev_valid = rx_valid;
    prev_busy  = busy;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the consumer-visible state
  logic [7:0] m_data;
  bit m_valid, m_ferr, m_ovr, m_perr;
  int fall_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sam_clk);
      #1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rx_data"},   rx_data,   m_data);
    check({tag, ".rx_valid"},  rx_valid,  m_valid);
    check({tag, ".frame_err"}, frame_err, m_ferr);
    check({tag, ".overrun"},   overrun,   m_ovr);
`ifdef UART_RX_PARITY_EN
    check({tag, ".parity_err"}, parity_err, m_perr);
`endif
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    step(1);
    rx_ack  = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  // Drives one whole frame; optional one-cycle inverted glitch and mid-frame ack.
  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_bad,
                            input int gl_bit, input int gl_off, input int ack_at);
    logic [10:0] bits;
    int lat;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ par_bad;
    bits[10] = stop_b;
`else
    bits[9]  = stop_b;
`endif
    for (int i = 0; i < c_NBITS; i++) begin
      for (int j = 0; j < c_BIT; j++) begin
        rx = (i == gl_bit && j == gl_off) ? ~bits[i] : bits[i];
        if (i == 0 && j == 0) fall_cyc = cyc;
        if (i * c_BIT + j == ack_at) begin
          check("ack_data", rx_data, m_data);
          rx_ack  = 1'b1;
          m_valid = 1'b0;
        end else begin
          rx_ack = 1'b0;
        end
        step(1);
      end
    end
    rx     = 1'b1;
    rx_ack = 1'b0;
    if (!m_valid) begin
      lat = valid_rise_cyc - fall_cyc;
      check("valid_latency", (lat >= c_LAT - 2 && lat <= c_LAT + 2) ? c_LAT : lat, c_LAT);
    end
    if (m_valid) m_ovr = 1'b1;
    m_data  = d;
    m_valid = 1'b1;
    if (!stop_b) m_ferr = 1'b1;
    if (par_bad) m_perr = 1'b1;
  endtask

  initial begin
    int k;
    int rises0;
    int bcyc0;
    logic [7:0] rd;
    bit rstop;
    int gb, go, aa;

    reset = 1'b0; rx = 1'b1; rx_ack = 1'b0; err_clr = 1'b0;
    m_data = 8'h00; m_valid = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
    step(3);
    check_all("reset");
    check("reset.busy", busy, 0);
    reset = 1'b1;
    step(20);

    // Single frame, no ack
    send_frame(8'h24, 1, 0, -1, 0, -1);
    check_all("single");
    check("busy_latency", busy_rise_cyc - fall_cyc, 3);
    step(2);
    check("busy_idle", busy, 0);

    // Back-to-back, ack during the second frame
    ack_pulse();
    send_frame(8'h24, 1, 0, -1, 0, -1);
    send_frame(8'h30, 1, 0, -1, 0, 40);
    check_all("b2b");

    // Overrun then clear
    ack_pulse();
    send_frame(8'h30, 1, 0, -1, 0, -1);
    send_frame(8'hC3, 1, 0, -1, 0, -1);
    check_all("overrun");
    clr_pulse();
    check_all("overrun_clr");

    // Bad stop bit
    ack_pulse();
    send_frame(8'h5A, 0, 0, -1, 0, -1);
    check_all("framing");
    step(24);
    clr_pulse();
    check_all("framing_clr");

    // Short low glitch on idle line
    rises0 = valid_rises;
    bcyc0  = busy_rise_cyc;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    check("glitch_busy_seen", busy_rise_cyc != bcyc0, 1);
    k = 0;
    while (busy && k < 12) begin
      step(1);
      k++;
    end
    check("glitch_busy_clear", busy, 0);
    step(30);
    check("glitch_no_valid", valid_rises - rises0, 0);

    // Data-bit glitch outvoted
    ack_pulse();
    send_frame(8'hA5, 1, 0, 4, 8, -1);
    check_all("data_glitch");

    // Reset during data bit 4
    ack_pulse();
    rx = 1'b0;
    step(c_BIT);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 2 || i == 3);
      step(c_BIT);
    end
    rx = 1'b1;
    step(8);
    reset = 1'b0;
    #2;
    m_data = 8'h00; m_valid = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
    check_all("mid_reset");
    check("mid_reset.busy", busy, 0);
    step(3);
    reset = 1'b1;
    step(20);
    send_frame(8'h81, 1, 0, -1, 0, -1);
    check_all("after_reset");

`ifdef UART_RX_PARITY_EN
    ack_pulse();
    send_frame(8'h07, 1, 1, -1, 0, -1);
    check_all("parity");
    clr_pulse();
`endif

    // Random frames
    for (int n = 0; n < 12; n++) begin
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) begin
        gb = $urandom_range(1, 8);
        go = $urandom_range(0, 15);
      end else begin
        gb = -1;
        go = 0;
      end
      aa = ($urandom_range(0, 1) == 1) ? $urandom_range(16, 120) : -1;
      send_frame(rd, rstop, 0, gb, go, aa);
      check_all("random");
      if ($urandom_range(0, 1) == 1) ack_pulse();
      if ($urandom_range(0, 3) == 0) clr_pulse();
      if (!rstop) step(24);
      else step($urandom_range(0, 8));
    end

    // Line break: repeated 0x00 frames with framing error
    ack_pulse();
    clr_pulse();
    rx = 1'b0;
    step(320);
    check("break.rx_data", rx_data, 8'h00);
    check("break.frame_err", frame_err, 1);
    check("break.rx_valid", rx_valid, 1);
    rx = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
